// File: rtl/tcp_misc_pkg.sv
// Teardown controller state encoding and a small counter helper.
package tcp_misc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        QUIESCE,
        CLR_CAM,
        RET_ID,
        SCHED,
        DONE
    } teardown_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

endpackage

// File: rtl/tcp_pkg.sv
// Shared TCP datapath sizing: flowid width and the CAM depth it implies.
package tcp_pkg;

    localparam int FLOWID_W     = 4;
    localparam int MAX_FLOW_CNT = 1 << FLOWID_W;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_val
);

    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        grant_val = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!grant_val && req[idx]) begin
                grant_val      = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/tcp_flow_teardown_ctrl.sv
// Serialises TCP flow teardown: arbitrate closers, drain rx, unmap CAM entry,
// return the flowid, then tell the scheduler. Stale closes are counted and dropped.
//
//   state   | meaning
//   IDLE    | arbitrating close requests, checking liveness
//   QUIESCE | waiting for rx pipeline between CAM lookup and state write to drain
//   CLR_CAM | one-cycle CAM clear strobe, live bit cleared
//   RET_ID  | offering flowid back to flowid_manager
//   SCHED   | asking scheduler to drop the flow
//   DONE    | one-cycle completion pulse
module tcp_flow_teardown_ctrl
    import tcp_misc_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int FLOWID_W     = tcp_pkg::FLOWID_W,
    parameter int MAX_FLOW_CNT = 1 << FLOWID_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_val,
    input  logic [NUM_REQ*FLOWID_W-1:0]   req_flowid,
    output logic [NUM_REQ-1:0]            req_rdy,
    input  logic                          new_flow_val,
    input  logic                          new_flow_rdy,
    input  logic [FLOWID_W-1:0]           new_flow_flowid,
    input  logic                          rx_pipe_idle,
    output logic [MAX_FLOW_CNT-1:0]       cam_clr_v,
    output logic                          flowid_ret_val,
    output logic [FLOWID_W-1:0]           flowid_ret_id,
    input  logic                          flowid_ret_rdy,
    output logic                          sched_clr_val,
    output logic [FLOWID_W-1:0]           sched_clr_flowid,
    input  logic                          sched_clr_rdy,
    output logic                          teardown_busy,
    output logic                          teardown_done,
    output logic [FLOWID_W-1:0]           teardown_done_flowid,
    output logic [15:0]                   drop_cnt
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    teardown_state_e         state_q, state_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [MAX_FLOW_CNT-1:0] live_q, live_d;
    logic [15:0]             drop_cnt_q, drop_cnt_d;
    logic [FLOWID_W-1:0]     flowid_q, flowid_d;

    logic [NUM_REQ-1:0]      grant;
    logic [IDX_W-1:0]        grant_idx;
    logic                    grant_val;
    logic [FLOWID_W-1:0]     acc_flowid;
    logic [MAX_FLOW_CNT-1:0] live_set;
    logic [MAX_FLOW_CNT-1:0] live_clr;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req       (req_val),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_val (grant_val)
    );

    assign acc_flowid = req_flowid[grant_idx*FLOWID_W +: FLOWID_W];
    assign live_set   = (new_flow_val && new_flow_rdy) ?
                        (MAX_FLOW_CNT'(1) << new_flow_flowid) : '0;

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        drop_cnt_d     = drop_cnt_q;
        flowid_d       = flowid_q;
        live_clr       = '0;
        req_rdy        = '0;
        cam_clr_v      = '0;
        flowid_ret_val = 1'b0;
        sched_clr_val  = 1'b0;
        teardown_done  = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_val) begin
                    req_rdy  = grant;
                    flowid_d = acc_flowid;
                    rr_ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
                    if (live_q[acc_flowid]) begin
                        state_d = QUIESCE;
                    end else begin
                        drop_cnt_d = sat_inc16(drop_cnt_q);
                    end
                end
            end
            QUIESCE: begin
                if (rx_pipe_idle) begin
                    state_d = CLR_CAM;
                end
            end
            CLR_CAM: begin
                cam_clr_v = MAX_FLOW_CNT'(1) << flowid_q;
                live_clr  = MAX_FLOW_CNT'(1) << flowid_q;
                state_d   = RET_ID;
            end
            RET_ID: begin
                flowid_ret_val = 1'b1;
                if (flowid_ret_rdy) begin
                    state_d = SCHED;
                end
            end
            SCHED: begin
                sched_clr_val = 1'b1;
                if (sched_clr_rdy) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                teardown_done = 1'b1;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // An install landing on the flow being cleared keeps it live.
        live_d = (live_q & ~live_clr) | live_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            live_q     <= '0;
            drop_cnt_q <= '0;
            flowid_q   <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            live_q     <= live_d;
            drop_cnt_q <= drop_cnt_d;
            flowid_q   <= flowid_d;
        end
    end

    assign flowid_ret_id        = flowid_q;
    assign sched_clr_flowid     = flowid_q;
    assign teardown_done_flowid = flowid_q;
    assign teardown_busy        = (state_q != IDLE);
    assign drop_cnt             = drop_cnt_q;

    live_set_clr_a: assert property (@(posedge clk) disable iff (rst)
        (live_set & live_clr) == '0);

endmodule
